// File: rtl/status_flag_controller.sv
// NZCV status tracker for an in-order pipeline: condition evaluation with
// same-cycle bypass, in-flight flag-setter accounting and taken-branch flush.
module status_flag_controller #(
    parameter int unsigned MAX_PENDING  = 2,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       issue_valid,
    input  logic [3:0] issue_cond,
    input  logic       issue_set_flags,
    input  logic       issue_is_branch,
    input  logic       flag_wr_valid,
    input  logic [3:0] flag_wr_data,
    output logic       issue_ready,
    output logic       cond_pass,
    output logic [3:0] status_q,
    output logic       flush,
    output logic [1:0] pending_cnt,
    output logic       wr_err
);

    localparam int unsigned CNT_W = 3;
    localparam logic [3:0]  COND_AL = 4'hE;
    localparam logic [1:0]  MAX_P   = 2'(MAX_PENDING);
    localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] fcnt_q, fcnt_d;
    logic             flush_d;
    logic [3:0]       eval_flags;
    logic             resolved;
    logic             accept;
    logic             inc;
    logic             dec;

    // Flags are ordered {z,c,n,v}.
    function automatic logic eval_cond(input logic [3:0] cond, input logic [3:0] f);
        logic z, c, n, v;
        z = f[3];
        c = f[2];
        n = f[1];
        v = f[0];
        case (cond)
            4'h0:    eval_cond = z;
            4'h1:    eval_cond = ~z;
            4'h2:    eval_cond = c;
            4'h3:    eval_cond = ~c;
            4'h4:    eval_cond = n;
            4'h5:    eval_cond = ~n;
            4'h6:    eval_cond = v;
            4'h7:    eval_cond = ~v;
            4'h8:    eval_cond = c & ~z;
            4'h9:    eval_cond = ~c | z;
            4'hA:    eval_cond = (n == v);
            4'hB:    eval_cond = (n != v);
            4'hC:    eval_cond = ~z & (n == v);
            4'hD:    eval_cond = z | (n != v);
            4'hE:    eval_cond = 1'b1;
            default: eval_cond = 1'b0;
        endcase
    endfunction

    // A return from the only in-flight setter is visible in the same cycle.
    assign eval_flags = (flag_wr_valid && pending_cnt == 2'd1) ? flag_wr_data : status_q;
    assign cond_pass  = eval_cond(issue_cond, eval_flags);
    assign resolved   = (pending_cnt == 2'd0) || (pending_cnt == 2'd1 && flag_wr_valid);
    assign accept     = issue_valid & issue_ready;
    assign inc        = accept & issue_set_flags & cond_pass;
    assign dec        = flag_wr_valid & (pending_cnt != 2'd0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            fcnt_q  <= '0;
            flush   <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            flush   <= flush_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            ST_RUN: begin
                if (accept && issue_is_branch && cond_pass) begin
                    state_d = ST_FLUSH;
                    fcnt_d  = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                if (fcnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    fcnt_d = fcnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
                fcnt_d  = '0;
            end
        endcase
    end

    // Output logic: issue handshake and the flush register's next value
    always_comb begin
        issue_ready = 1'b1;
        flush_d     = (state_d == ST_FLUSH);
        if (state_q == ST_FLUSH) begin
            issue_ready = 1'b0;
        end
        if (issue_cond != COND_AL && !resolved) begin
            issue_ready = 1'b0;
        end
        if (issue_set_flags && pending_cnt == MAX_P && !flag_wr_valid) begin
            issue_ready = 1'b0;
        end
    end

    // Architectural flags, in-flight count and sticky stray-return error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            status_q    <= '0;
            pending_cnt <= '0;
            wr_err      <= 1'b0;
        end else begin
            if (dec) begin
                status_q <= flag_wr_data;
            end
            if (flag_wr_valid && pending_cnt == 2'd0) begin
                wr_err <= 1'b1;
            end
            case ({inc, dec})
                2'b10:   pending_cnt <= pending_cnt + 2'd1;
                2'b01:   pending_cnt <= pending_cnt - 2'd1;
                default: pending_cnt <= pending_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_status_flag_controller.sv
// Bench for status_flag_controller: condition-code truth table, directed
// multi-cycle sequences and random traffic against a behavioural model.
module tb_status_flag_controller;

    localparam int MAXP  = 2;
    localparam int FLUSH = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid;
    logic [3:0] issue_cond;
    logic       issue_set_flags;
    logic       issue_is_branch;
    logic       flag_wr_valid;
    logic [3:0] flag_wr_data;
    logic       issue_ready;
    logic       cond_pass;
    logic [3:0] status_q;
    logic       flush;
    logic [1:0] pending_cnt;
    logic       wr_err;

    status_flag_controller #(.MAX_PENDING(MAXP), .FLUSH_CYCLES(FLUSH)) dut (
        .clk            (clk),
        .rst            (rst),
        .issue_valid    (issue_valid),
        .issue_cond     (issue_cond),
        .issue_set_flags(issue_set_flags),
        .issue_is_branch(issue_is_branch),
        .flag_wr_valid  (flag_wr_valid),
        .flag_wr_data   (flag_wr_data),
        .issue_ready    (issue_ready),
        .cond_pass      (cond_pass),
        .status_q       (status_q),
        .flush          (flush),
        .pending_cnt    (pending_cnt),
        .wr_err         (wr_err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    int         m_pend;
    logic [3:0] m_status;
    int         m_flush_left;
    bit         m_err;

    typedef struct {
        logic [3:0]  cond;
        logic [15:0] pass_mask;  // bit f set when the code passes with flags f={z,c,n,v}
    } cc_vec_t;

    cc_vec_t cc_tab[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ref_cond(input logic [3:0] cond, input logic [3:0] f);
        bit z, c, n, v;
        z = f[3]; c = f[2]; n = f[1]; v = f[0];
        case (cond)
            4'h0: return z;
            4'h1: return !z;
            4'h2: return c;
            4'h3: return !c;
            4'h4: return n;
            4'h5: return !n;
            4'h6: return v;
            4'h7: return !v;
            4'h8: return c && !z;
            4'h9: return !c || z;
            4'hA: return n == v;
            4'hB: return n != v;
            4'hC: return !z && (n == v);
            4'hD: return z || (n != v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_pend = 0;
        m_status = 4'h0;
        m_flush_left = 0;
        m_err = 0;
    endtask

    // One clock: drive after negedge, check against model, then advance the model.
    task automatic cyc(input logic v, input logic [3:0] cond, input logic sf, input logic br,
                       input logic fwv, input logic [3:0] fwd);
        logic [3:0] flags;
        bit exp_pass, exp_ready, resolved, acc;
        @(negedge clk);
        issue_valid = v; issue_cond = cond; issue_set_flags = sf;
        issue_is_branch = br; flag_wr_valid = fwv; flag_wr_data = fwd;
        #1;
        flags     = (fwv && m_pend == 1) ? fwd : m_status;
        exp_pass  = ref_cond(cond, flags);
        resolved  = (m_pend == 0) || (m_pend == 1 && fwv);
        exp_ready = (m_flush_left == 0) && !(cond != 4'hE && !resolved) &&
                    !(sf && m_pend == MAXP && !fwv);
        chk("m_cond_pass",   32'(cond_pass),   32'(exp_pass));
        chk("m_issue_ready", 32'(issue_ready), 32'(exp_ready));
        chk("m_status_q",    32'(status_q),    32'(m_status));
        chk("m_pending_cnt", 32'(pending_cnt), 32'(m_pend));
        chk("m_flush",       32'(flush),       32'(m_flush_left > 0));
        chk("m_wr_err",      32'(wr_err),      32'(m_err));
        acc = v && exp_ready;
        if (fwv && m_pend > 0) begin
            m_status = fwd;
            m_pend--;
        end else if (fwv) begin
            m_err = 1;
        end
        if (acc && sf && exp_pass) m_pend++;
        if (m_flush_left > 0) m_flush_left--;
        else if (acc && br && exp_pass) m_flush_left = FLUSH;
    endtask

    task automatic idle();
        cyc(0, 4'hE, 0, 0, 0, 4'h0);
    endtask

    // Load status_q with f through an accepted setter and its return.
    task automatic load_flags(input logic [3:0] f);
        cyc(1, 4'hE, 1, 0, 0, 4'h0);
        cyc(0, 4'hE, 0, 0, 1, f);
    endtask

    logic [3:0] saved;

    initial begin
        cc_tab[0]  = '{4'h0, 16'hFF00};
        cc_tab[1]  = '{4'h1, 16'h00FF};
        cc_tab[2]  = '{4'h2, 16'hF0F0};
        cc_tab[3]  = '{4'h3, 16'h0F0F};
        cc_tab[4]  = '{4'h4, 16'hCCCC};
        cc_tab[5]  = '{4'h5, 16'h3333};
        cc_tab[6]  = '{4'h6, 16'hAAAA};
        cc_tab[7]  = '{4'h7, 16'h5555};
        cc_tab[8]  = '{4'h8, 16'h00F0};
        cc_tab[9]  = '{4'h9, 16'hFF0F};
        cc_tab[10] = '{4'hA, 16'h9999};
        cc_tab[11] = '{4'hB, 16'h6666};
        cc_tab[12] = '{4'hC, 16'h0099};
        cc_tab[13] = '{4'hD, 16'hFF66};
        cc_tab[14] = '{4'hE, 16'hFFFF};
        cc_tab[15] = '{4'hF, 16'h0000};

        rst = 1'b1;
        issue_valid = 0; issue_cond = 4'hE; issue_set_flags = 0;
        issue_is_branch = 0; flag_wr_valid = 0; flag_wr_data = 4'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_status", 32'(status_q), 32'h0);
        chk("rst_pending", 32'(pending_cnt), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_wr_err", 32'(wr_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // EQ on cleared flags fails; after loading z it passes
        cyc(1, 4'h0, 0, 0, 0, 4'h0);
        chk("eq_clear_pass", 32'(cond_pass), 32'h0);
        chk("eq_clear_ready", 32'(issue_ready), 32'h1);
        load_flags(4'h8);
        cyc(1, 4'h0, 0, 0, 0, 4'h0);
        chk("eq_z_pass", 32'(cond_pass), 32'h1);
        chk("eq_z_status", 32'(status_q), 32'h8);

        // Stall on unresolved flags, then same-cycle bypass
        load_flags(4'h0);
        cyc(1, 4'hE, 1, 0, 0, 4'h0);
        cyc(1, 4'h0, 0, 0, 0, 4'h0);
        chk("byp_pend1", 32'(pending_cnt), 32'h1);
        chk("byp_stall", 32'(issue_ready), 32'h0);
        cyc(1, 4'h0, 0, 0, 1, 4'h8);
        chk("byp_ready", 32'(issue_ready), 32'h1);
        chk("byp_pass", 32'(cond_pass), 32'h1);

        // Failed-condition setter does not count as in flight
        idle();
        cyc(1, 4'hF, 1, 0, 0, 4'h0);
        chk("nv_setter_ready", 32'(issue_ready), 32'h1);
        idle();
        chk("nv_setter_pend", 32'(pending_cnt), 32'h0);

        // Max-pending stall and replace-on-return
        cyc(1, 4'hE, 1, 0, 0, 4'h0);
        cyc(1, 4'hE, 1, 0, 0, 4'h0);
        cyc(1, 4'hE, 1, 0, 0, 4'h0);
        chk("max_pend2", 32'(pending_cnt), 32'h2);
        chk("max_stall", 32'(issue_ready), 32'h0);
        cyc(1, 4'hE, 1, 0, 1, 4'h3);
        chk("max_swap_ready", 32'(issue_ready), 32'h1);
        idle();
        chk("max_swap_pend", 32'(pending_cnt), 32'h2);
        chk("max_swap_status", 32'(status_q), 32'h3);
        cyc(0, 4'hE, 0, 0, 1, 4'h1);
        cyc(0, 4'hE, 0, 0, 1, 4'h2);
        idle();
        chk("drain_pend", 32'(pending_cnt), 32'h0);

        // Taken AL branch flushes for two cycles
        cyc(1, 4'hE, 0, 1, 0, 4'h0);
        cyc(1, 4'hE, 0, 0, 0, 4'h0);
        chk("br_flush_t1", 32'(flush), 32'h1);
        chk("br_ready_t1", 32'(issue_ready), 32'h0);
        cyc(1, 4'hE, 0, 0, 0, 4'h0);
        chk("br_flush_t2", 32'(flush), 32'h1);
        chk("br_ready_t2", 32'(issue_ready), 32'h0);
        cyc(1, 4'hE, 0, 0, 0, 4'h0);
        chk("br_flush_t3", 32'(flush), 32'h0);
        chk("br_ready_t3", 32'(issue_ready), 32'h1);

        // Not-taken NE branch with z=1
        load_flags(4'h8);
        cyc(1, 4'h1, 0, 1, 0, 4'h0);
        chk("ne_pass", 32'(cond_pass), 32'h0);
        idle();
        chk("ne_noflush", 32'(flush), 32'h0);

        // Stray flag return is sticky and leaves status alone
        saved = status_q;
        cyc(0, 4'hE, 0, 0, 1, 4'h5);
        idle();
        chk("err_set", 32'(wr_err), 32'h1);
        chk("err_status", 32'(status_q), 32'(saved));
        repeat (3) idle();
        chk("err_sticky", 32'(wr_err), 32'h1);

        // Every condition code against every flag value
        for (int f = 0; f < 16; f++) begin
            load_flags(4'(f));
            for (int c = 0; c < 16; c++) begin
                cyc(0, cc_tab[c].cond, 0, 0, 0, 4'h0);
                chk($sformatf("cc%0h_f%0h", c, f), 32'(cond_pass), 32'(cc_tab[c].pass_mask[f]));
            end
        end

        // Reset in the middle of a flush window
        cyc(1, 4'hE, 1, 1, 0, 4'h0);
        idle();
        chk("midrst_flush_on", 32'(flush), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_flush", 32'(flush), 32'h0);
        chk("midrst_pend", 32'(pending_cnt), 32'h0);
        chk("midrst_err", 32'(wr_err), 32'h0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 4'hE, 0, 0, 0, 4'h0);
        chk("midrst_ready", 32'(issue_ready), 32'h1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] rc;
            rc = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hE;
            cyc(1'($urandom_range(0, 3) != 0), rc,
                1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0),
                1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/status_flag_controller.md
STATUS_FLAG_CONTROLLER -- requirements
Module: status_flag_controller

Interface
REQ-001 The block SHALL have parameter MAX_PENDING, default 2, giving the maximum number of in-flight flag-setting instructions (range 1..3).
REQ-002 The block SHALL have parameter FLUSH_CYCLES, default 2, giving the number of cycles flush is held after a taken branch (range 1..7).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port issue_valid, input, 1 bit: the ID stage presents an instruction.
REQ-006 The block SHALL have port issue_cond, input, 4 bits: the instruction condition field.
REQ-007 The block SHALL have port issue_set_flags, input, 1 bit: the instruction will write NZCV (S bit).
REQ-008 The block SHALL have port issue_is_branch, input, 1 bit: the instruction is a branch.
REQ-009 The block SHALL have port flag_wr_valid, input, 1 bit: the EXE stage returns flags from the oldest pending flag-setter.
REQ-010 The block SHALL have port flag_wr_data, input, 4 bits: returned flags, ordered {z,c,n,v}.
REQ-011 The block SHALL have port issue_ready, output, 1 bit: the instruction is accepted this cycle.
REQ-012 The block SHALL have port cond_pass, output, 1 bit: the condition of the presented instruction evaluates true (combinational).
REQ-013 The block SHALL have port status_q, output, 4 bits: the architectural status register, ordered {z,c,n,v}.
REQ-014 The block SHALL have port flush, output, 1 bit: a registered pipeline flush request.
REQ-015 The block SHALL have port pending_cnt, output, 2 bits: the number of in-flight flag-setters.
REQ-016 The block SHALL have port wr_err, output, 1 bit: a sticky flag indicating a flag return arrived with pending_cnt 0.

Function
REQ-017 The block SHALL define accept as issue_valid & issue_ready.
REQ-018 The block SHALL evaluate the condition as follows: EQ 0000 = z; NE 0001 = ~z; CS 0010 = c; CC 0011 = ~c; MI 0100 = n; PL 0101 = ~n; VS 0110 = v; VC 0111 = ~v; HI 1000 = c&~z; LS 1001 = ~c|z; GE 1010 = n==v; LT 1011 = n!=v; GT 1100 = ~z&(n==v); LE 1101 = z|(n!=v); AL 1110 = 1; 1111 = 0.
REQ-019 The block SHALL select the evaluation flags as follows: flag_wr_data if flag_wr_valid and pending_cnt==1 (bypass); otherwise status_q.
REQ-020 The block SHALL treat flags as resolved when pending_cnt==0, or when pending_cnt==1 and flag_wr_valid.
REQ-021 The block SHALL deassert issue_ready when state is FLUSH.
REQ-022 The block SHALL deassert issue_ready when issue_cond!=AL and flags are unresolved.
REQ-023 The block SHALL deassert issue_ready when issue_set_flags and pending_cnt==MAX_PENDING and not flag_wr_valid.
REQ-024 The block SHALL otherwise assert issue_ready, independent of issue_valid.
REQ-025 On flag_wr_valid with pending_cnt>0, the block SHALL load status_q<=flag_wr_data and decrement pending_cnt.
REQ-026 The block SHALL increment pending_cnt on accept with issue_set_flags and cond_pass; a failed-condition setter SHALL NOT increment.
REQ-027 On a simultaneous increment and decrement, pending_cnt SHALL be unchanged and status_q SHALL still load.
REQ-028 On flag_wr_valid with pending_cnt==0, the block SHALL leave status_q and pending_cnt unchanged and set wr_err; wr_err SHALL be cleared only by rst.
REQ-029 The block SHALL implement FSM state RUN: on accept with issue_is_branch and cond_pass, go to FLUSH and load the flush counter with FLUSH_CYCLES-1.
REQ-030 In FSM state FLUSH, flush SHALL be 1 and the counter SHALL decrement each cycle; at counter 0, the FSM SHALL return to RUN.
REQ-031 flush SHALL be asserted from the cycle after the branch is accepted, for exactly FLUSH_CYCLES cycles.
REQ-032 Flag returns SHALL be processed normally during FLUSH.
REQ-033 A branch that is not taken SHALL cause no state change.

Reset
REQ-034 While rst=1, the block SHALL force status_q=0000, pending_cnt=0, flush=0, wr_err=0, state=RUN and flush counter=0, asynchronously.
REQ-035 A reset asserted mid-FLUSH SHALL drop flush immediately, and the block SHALL resume in RUN with issue_ready=1 for an AL instruction on the first edge after rst falls.

Verification
REQ-036 Reset, then EQ with status 0000 -> cond_pass=0, issue_ready=1; load z via setter+return -> EQ passes.
REQ-037 Setter accepted (pending_cnt 1), next cycle EQ presented with no return -> issue_ready=0; return flag_wr_data=1000 -> same-cycle bypass issue_ready=1, cond_pass=1.
REQ-038 MAX_PENDING=2, two setters accepted -> third setter stalled; third setter with flag_wr_valid in same cycle -> accepted, pending_cnt stays 2.
REQ-039 Taken AL branch at cycle t -> flush=1 at t+1 and t+2, issue_ready=0 there, flush=0 at t+3; NE branch with z=1 -> no flush.
REQ-040 flag_wr_valid with pending_cnt 0 -> wr_err=1 persists and status_q unchanged; all 16 condition codes checked against all 16 flag values versus the REQ-018 table, including 1111 -> 0.
REQ-041 rst pulsed in the middle of a FLUSH window -> flush drops immediately and pending_cnt=0.
